// File: rtl/l2c_mem_pkg.sv
// Shared L2 cache storage constants and the l2c_mem FSM state encoding.
package l2c_mem_pkg;
  localparam int L2C_WAY_NUM = 4;
  localparam int L2C_INDEX_W = 8;
  localparam int L2C_TAG_W   = 18;
  localparam int CORE_DATA_W = 32;

  typedef enum logic [1:0] {
    L2C_MEM_ST_INIT   = 2'd0,
    L2C_MEM_ST_IDLE   = 2'd1,
    L2C_MEM_ST_ACCESS = 2'd2,
    L2C_MEM_ST_RDY    = 2'd3
  } l2c_mem_st_e;
endpackage

// File: rtl/l2c_mem_way.sv
// One L2 way: tag/data RAMs (no reset), valid/dirty flop vectors, registered read port.
module l2c_mem_way
  import l2c_mem_pkg::*;
#(
  parameter int INDEX_W = L2C_INDEX_W,
  parameter int TAG_W   = L2C_TAG_W,
  parameter int DATA_W  = CORE_DATA_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rd_en_i,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               wr_valid_i,
  input  logic               wr_dirty_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [DATA_W-1:0]  rd_data_o
);
  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS];
  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_dirty_q;

  // Gated by reset so an access aborted by reset never commits.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !rst_i) begin
      tag_mem[index_i]  <= wr_tag_i;
      data_mem[index_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      rd_tag_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_dirty_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        valid_q[index_i] <= wr_valid_i;
        dirty_q[index_i] <= wr_dirty_i;
      end
      // Same-edge read captures pre-write contents.
      if (rd_en_i) begin
        rd_tag_q   <= tag_mem[index_i];
        rd_data_q  <= data_mem[index_i];
        rd_valid_q <= valid_q[index_i];
        rd_dirty_q <= dirty_q[index_i];
      end
    end
  end

  assign rd_tag_o   = rd_tag_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_dirty_o = rd_dirty_q;
endmodule

// File: rtl/l2c_mem.sv
// L2 cache storage stage: capture request, read-before-write all ways, pulse rw_rdy.
// Define L2C_MEM_INIT_EN to zero tag/data of every set after reset (INIT sweep).
module l2c_mem
  import l2c_mem_pkg::*;
#(
  parameter int WAY_NUM = L2C_WAY_NUM,
  parameter int INDEX_W = L2C_INDEX_W,
  parameter int TAG_W   = L2C_TAG_W,
  parameter int DATA_W  = CORE_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      rw_req,
  input  logic [INDEX_W-1:0]        rw_index,
  input  logic [WAY_NUM-1:0]        wr_en_pack,
  input  logic [TAG_W*WAY_NUM-1:0]  wr_tag_pack,
  input  logic [WAY_NUM-1:0]        wr_valid_pack,
  input  logic [WAY_NUM-1:0]        wr_dirty_pack,
  input  logic [DATA_W*WAY_NUM-1:0] wr_data_pack,
  output logic                      rw_rdy,
  output logic [TAG_W*WAY_NUM-1:0]  rd_tag_pack,
  output logic [WAY_NUM-1:0]        rd_valid_pack,
  output logic [WAY_NUM-1:0]        rd_dirty_pack,
  output logic [DATA_W*WAY_NUM-1:0] rd_data_pack
);
  l2c_mem_st_e state_q, state_d;
  logic                      cap;
  logic                      init_last;
  logic [INDEX_W-1:0]        init_idx;
  logic [INDEX_W-1:0]        idx_q;
  logic [WAY_NUM-1:0]        wen_q, wvalid_q, wdirty_q;
  logic [TAG_W*WAY_NUM-1:0]  wtag_q;
  logic [DATA_W*WAY_NUM-1:0] wdata_q;

`ifdef L2C_MEM_INIT_EN
  localparam l2c_mem_st_e RST_ST = L2C_MEM_ST_INIT;
  logic [INDEX_W-1:0] init_idx_q;

  always_ff @(posedge clk) begin
    if (rst_)                         init_idx_q <= '0;
    else if (state_q == L2C_MEM_ST_INIT) init_idx_q <= init_idx_q + 1'b1;
  end

  assign init_idx  = init_idx_q;
  assign init_last = (init_idx_q == {INDEX_W{1'b1}});
`else
  localparam l2c_mem_st_e RST_ST = L2C_MEM_ST_IDLE;
  assign init_idx  = '0;
  assign init_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst_) state_q <= RST_ST;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      L2C_MEM_ST_INIT:   if (init_last) state_d = L2C_MEM_ST_IDLE;
      L2C_MEM_ST_IDLE:   if (rw_req) begin
                           cap     = 1'b1;
                           state_d = L2C_MEM_ST_ACCESS;
                         end
      L2C_MEM_ST_ACCESS: state_d = L2C_MEM_ST_RDY;
      L2C_MEM_ST_RDY:    state_d = L2C_MEM_ST_IDLE;
      default:           state_d = L2C_MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      idx_q    <= '0;
      wen_q    <= '0;
      wvalid_q <= '0;
      wdirty_q <= '0;
      wtag_q   <= '0;
      wdata_q  <= '0;
    end else if (cap) begin
      idx_q    <= rw_index;
      wen_q    <= wr_en_pack;
      wvalid_q <= wr_valid_pack;
      wdirty_q <= wr_dirty_pack;
      wtag_q   <= wr_tag_pack;
      wdata_q  <= wr_data_pack;
    end
  end

  logic                      init_mode, rd_en;
  logic [INDEX_W-1:0]        mem_idx;
  logic [WAY_NUM-1:0]        way_we, way_valid, way_dirty;
  logic [TAG_W*WAY_NUM-1:0]  way_tag;
  logic [DATA_W*WAY_NUM-1:0] way_data;

  // INIT borrows the write port to store zeros into every way at the sweep index.
  always_comb begin
    init_mode = (state_q == L2C_MEM_ST_INIT);
    rd_en     = (state_q == L2C_MEM_ST_ACCESS);
    mem_idx   = init_mode ? init_idx : idx_q;
    way_we    = init_mode ? '1 : (rd_en ? wen_q : '0);
    way_valid = init_mode ? '0 : wvalid_q;
    way_dirty = init_mode ? '0 : wdirty_q;
    way_tag   = init_mode ? '0 : wtag_q;
    way_data  = init_mode ? '0 : wdata_q;
  end

  for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
    l2c_mem_way #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
    ) u_way (
      .clk_i      (clk),
      .rst_i      (rst_),
      .rd_en_i    (rd_en),
      .wr_en_i    (way_we[g]),
      .index_i    (mem_idx),
      .wr_tag_i   (way_tag[g*TAG_W +: TAG_W]),
      .wr_valid_i (way_valid[g]),
      .wr_dirty_i (way_dirty[g]),
      .wr_data_i  (way_data[g*DATA_W +: DATA_W]),
      .rd_tag_o   (rd_tag_pack[g*TAG_W +: TAG_W]),
      .rd_valid_o (rd_valid_pack[g]),
      .rd_dirty_o (rd_dirty_pack[g]),
      .rd_data_o  (rd_data_pack[g*DATA_W +: DATA_W])
    );
  end

  assign rw_rdy = (state_q == L2C_MEM_ST_RDY);
endmodule

// File: tb/tb_l2c_mem.sv
// Scoreboard bench for l2c_mem: driver pushes expected read-back, negedge monitor compares.
module tb_l2c_mem;
  localparam int WN = 4, IW = 8, TW = 18, DW = 32, SETS = 256;

  logic                 clk = 1'b0;
  logic                 rst_ = 1'b1;
  logic                 rw_req = 1'b0;
  logic [IW-1:0]        rw_index = '0;
  logic [WN-1:0]        wr_en_pack = '0, wr_valid_pack = '0, wr_dirty_pack = '0;
  logic [TW*WN-1:0]     wr_tag_pack = '0;
  logic [DW*WN-1:0]     wr_data_pack = '0;
  logic                 rw_rdy;
  logic [TW*WN-1:0]     rd_tag_pack;
  logic [WN-1:0]        rd_valid_pack, rd_dirty_pack;
  logic [DW*WN-1:0]     rd_data_pack;

  l2c_mem dut (
    .clk(clk), .rst_(rst_), .rw_req(rw_req), .rw_index(rw_index),
    .wr_en_pack(wr_en_pack), .wr_tag_pack(wr_tag_pack), .wr_valid_pack(wr_valid_pack),
    .wr_dirty_pack(wr_dirty_pack), .wr_data_pack(wr_data_pack), .rw_rdy(rw_rdy),
    .rd_tag_pack(rd_tag_pack), .rd_valid_pack(rd_valid_pack),
    .rd_dirty_pack(rd_dirty_pack), .rd_data_pack(rd_data_pack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW*WN-1:0] tag;
    logic [WN-1:0]    v, d, known;
    logic [DW*WN-1:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // Reference contents; known=0 means tag/data never written since power-up.
  logic [TW-1:0] m_tag  [SETS][WN];
  logic [DW-1:0] m_data [SETS][WN];
  bit            m_v [SETS][WN], m_d [SETS][WN], m_k [SETS][WN];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WN; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
`ifdef L2C_MEM_INIT_EN
        m_tag[s][w] = '0; m_data[s][w] = '0; m_k[s][w] = 1'b1;
`endif
      end
  endtask

  logic prev_rdy = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (rw_rdy) begin
      chk("rdy_isolated", {127'b0, prev_rdy}, 128'd0);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rdy: got rw_rdy=1 expected no pending access");
      end else begin
        me = q.pop_front();
        chk("rd_valid", rd_valid_pack, me.v);
        chk("rd_dirty", rd_dirty_pack, me.d);
        for (int w = 0; w < WN; w++)
          if (me.known[w]) begin
            chk($sformatf("rd_tag_w%0d", w), rd_tag_pack[w*TW +: TW], me.tag[w*TW +: TW]);
            chk($sformatf("rd_data_w%0d", w), rd_data_pack[w*DW +: DW], me.data[w*DW +: DW]);
          end
      end
    end
    prev_rdy <= rw_rdy;
  end

  // One access; keep leaves rw_req high, lat checks 2-cycle latency and scrambles inputs in ACCESS.
  task automatic access(input logic [IW-1:0] idx, input logic [WN-1:0] wen,
                        input logic [TW*WN-1:0] tp, input logic [WN-1:0] vp, input logic [WN-1:0] dp,
                        input logic [DW*WN-1:0] dat, input bit keep, input bit lat, output int n);
    exp_t e;
    @(negedge clk);
    rw_index = idx; wr_en_pack = wen; wr_tag_pack = tp;
    wr_valid_pack = vp; wr_dirty_pack = dp; wr_data_pack = dat; rw_req = 1'b1;
    for (int w = 0; w < WN; w++) begin
      e.tag[w*TW +: TW]  = m_tag[idx][w];
      e.data[w*DW +: DW] = m_data[idx][w];
      e.v[w] = m_v[idx][w]; e.d[w] = m_d[idx][w]; e.known[w] = m_k[idx][w];
      if (wen[w]) begin
        m_tag[idx][w] = tp[w*TW +: TW]; m_data[idx][w] = dat[w*DW +: DW];
        m_v[idx][w] = vp[w]; m_d[idx][w] = dp[w]; m_k[idx][w] = 1'b1;
      end
    end
    q.push_back(e);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      if (lat && n == 1) begin
        rw_index = ~idx; wr_en_pack = ~wen; wr_tag_pack = ~tp;
        wr_valid_pack = ~vp; wr_dirty_pack = ~dp; wr_data_pack = ~dat;
      end
    end while (!rw_rdy && n < 600);
    if (!rw_rdy) begin
      checks++; errors++;
      $display("FAIL rdy_timeout: got no rw_rdy after %0d cycles expected a pulse", n);
    end else if (lat) chk("latency", n, 2);
    if (!keep) rw_req = 1'b0;
  endtask

  task automatic rd(input logic [IW-1:0] idx);
    int n;
    access(idx, '0, '0, '0, '0, '0, 1'b0, 1'b1, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b1; rw_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b0;
    model_reset();
`ifdef L2C_MEM_INIT_EN
    repeat (SETS + 4) @(negedge clk);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WN; w++) begin
        m_tag[s][w] = '0; m_data[s][w] = '0; m_k[s][w] = 1'b0;
      end
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rdy", rw_rdy, 0);
    chk("reset_rd_valid", rd_valid_pack, 0);
    chk("reset_rd_dirty", rd_dirty_pack, 0);
    chk("reset_rd_tag", rd_tag_pack, 0);
    chk("reset_rd_data", rd_data_pack, 0);
    rst_ = 1'b0;

`ifdef L2C_MEM_INIT_EN
    // Request raised 11 cycles into the 256-cycle sweep: rdy after 256+2-11 edges.
    repeat (10) @(negedge clk);
    access(8'h05, '0, '0, '0, '0, '0, 1'b0, 1'b0, n);
    chk("sweep_wait", n, 247);
`else
    rd(8'h05);
`endif

    // Known baseline for set 0x12, then the way2 write with old contents returned.
    access(8'h12, 4'b1111, '0, '0, '0, '0, 1'b0, 1'b1, n);
    access(8'h12, 4'b0100, {18'h0, 18'h2ABCD, 18'h0, 18'h0}, 4'b0100, 4'b0100,
           {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 1'b0, 1'b1, n);
    rd(8'h12);
    // Read-before-write on way2.
    access(8'h12, 4'b0100, {18'h0, 18'h2ABCD, 18'h0, 18'h0}, 4'b0100, 4'b0100,
           {32'h0, 32'h11111111, 32'h0, 32'h0}, 1'b0, 1'b1, n);
    rd(8'h12);

    // rw_req held across back-to-back accesses, including the 0xFF wrap set.
    access(8'h00, 4'b1111, {18'h00001, 18'h00002, 18'h00003, 18'h00004}, 4'b1010, 4'b0110,
           {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3}, 1'b1, 1'b1, n);
    access(8'hFF, 4'b1111, {18'h3FFFF, 18'h20001, 18'h15555, 18'h0AAAA}, 4'b1111, 4'b0101,
           {32'hFFFFFFFF, 32'h80000001, 32'h55555555, 32'hAAAAAAAA}, 1'b1, 1'b1, n);
    access(8'hFF, 4'b0001, {18'h0, 18'h0, 18'h0, 18'h12345}, 4'b0000, 4'b0001,
           {32'h0, 32'h0, 32'h0, 32'h0BADF00D}, 1'b1, 1'b1, n);
    access(8'h00, '0, '0, '0, '0, '0, 1'b0, 1'b1, n);
    rd(8'hFF);

    // Reset during ACCESS: no pulse, no commit, valid/dirty cleared.
    @(negedge clk);
    rw_index = 8'h12; wr_en_pack = 4'b1111; rw_req = 1'b1;
    wr_tag_pack = {4{18'h1F0F0}}; wr_valid_pack = 4'b1111; wr_dirty_pack = 4'b1111;
    wr_data_pack = {4{32'hCAFEF00D}};
    @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1; rw_req = 1'b0;
    @(negedge clk);
    chk("abort_rdy", rw_rdy, 0);
    chk("abort_rd_valid", rd_valid_pack, 0);
    rst_ = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rdy", rw_rdy, 0);
    end
`ifdef L2C_MEM_INIT_EN
    repeat (SETS + 4) @(negedge clk);
`endif
    rd(8'h12);
    rd(8'hFF);

    do_reset();
    rd(8'h00);

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
